// File: rtl/color_detector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | color_detector_pkg                                                     |
// | Shared types, window geometry and winner selection for color_detector. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package color_detector_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_e;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_ACCUM    = 1'b1
  } state_e;

  localparam int              CNT_W       = 15;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [9:0]      ROI_X_END   = 10'd320;
  localparam logic [9:0]      ROI_Y_START = 10'd240;
  localparam logic [9:0]      ROI_Y_END   = 10'd480;
  localparam logic [9:0]      EOF_ROW     = 10'd480;

  // Largest count wins, ties resolved RED > GREEN > BLUE.
  function automatic color_e pick_winner(
    input logic [CNT_W-1:0] r,
    input logic [CNT_W-1:0] g,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] min_pixels
  );
    color_e           w;
    logic [CNT_W-1:0] c;
    if (r >= g && r >= b) begin
      w = RED;
      c = r;
    end else if (g >= b) begin
      w = GREEN;
      c = g;
    end else begin
      w = BLUE;
      c = b;
    end
    if (c < min_pixels) begin
      w = NONE;
    end
    return w;
  endfunction

endpackage : color_detector_pkg
`default_nettype wire

// File: rtl/rgb565_classifier.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rgb565_classifier                                                      |
// | Combinational per-pixel dominant-channel classifier for RGB565 data.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module rgb565_classifier
  import color_detector_pkg::*;
#(
  parameter logic [4:0] SAT_MIN = 5'd12,
  parameter logic [4:0] MARGIN  = 5'd4
) (
  input  logic [15:0] rgb565,
  output color_e      color
);

  logic [5:0] r6;
  logic [5:0] g6;
  logic [5:0] b6;
  logic [5:0] m6;
  logic       is_red;
  logic       is_green;
  logic       is_blue;
  logic       unused_g_lsb;

  // Green uses its top five bits so all channels compare on the same scale.
  assign r6           = {1'b0, rgb565[15:11]};
  assign g6           = {1'b0, rgb565[10:6]};
  assign b6           = {1'b0, rgb565[4:0]};
  assign m6           = {1'b0, MARGIN};
  assign unused_g_lsb = rgb565[5];

  assign is_red   = (r6[4:0] >= SAT_MIN) && (r6 >= g6 + m6) && (r6 >= b6 + m6);
  assign is_green = (g6[4:0] >= SAT_MIN) && (g6 >= r6 + m6) && (g6 >= b6 + m6);
  assign is_blue  = (b6[4:0] >= SAT_MIN) && (b6 >= r6 + m6) && (b6 >= g6 + m6);

  always_comb begin
    color = NONE;
    if (is_red) begin
      color = RED;
    end else if (is_green) begin
      color = GREEN;
    end else if (is_blue) begin
      color = BLUE;
    end
  end

endmodule : rgb565_classifier
`default_nettype wire

// File: rtl/color_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | color_detector                                                         |
// | Per-frame dominant colour classifier over the 2x-upscaled dice window. |
// | Optional: COLOR_DETECTOR_STABLE_EN gates color_id on repeated results. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module color_detector
  import color_detector_pkg::*;
#(
  parameter logic [4:0]       SAT_MIN       = 5'd12,
  parameter logic [4:0]       MARGIN        = 5'd4,
  parameter logic [CNT_W-1:0] MIN_PIXELS    = 15'd500,
  parameter int               STABLE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DE,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic [15:0]      rgb565,
  output logic [1:0]       color_id,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic             color_valid
);

  logic             de_dly_q, de_dly_d;
  logic [9:0]       x_dly_q, x_dly_d;
  logic [9:0]       y_dly_q, y_dly_d;
  logic             aln_vld_q, aln_vld_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] red_acc_q, red_acc_d;
  logic [CNT_W-1:0] green_acc_q, green_acc_d;
  logic [CNT_W-1:0] blue_acc_q, blue_acc_d;
  logic [CNT_W-1:0] red_out_q, red_out_d;
  logic [CNT_W-1:0] green_out_q, green_out_d;
  logic [CNT_W-1:0] blue_out_q, blue_out_d;
  color_e           color_id_q, color_id_d;
  logic             color_valid_q, color_valid_d;

  color_e           pix_class;
  color_e           raw_winner;
  logic             sof;
  logic             eof;
  logic             sample;

`ifdef COLOR_DETECTOR_STABLE_EN
  localparam logic [2:0] STAB_CNT = 3'(STABLE_FRAMES);
  logic [2:0] rep_q, rep_d;
  color_e     last_raw_q, last_raw_d;
`else
  logic       unused_stable_cfg;
  assign unused_stable_cfg = (STABLE_FRAMES != 0);
`endif

  rgb565_classifier #(
    .SAT_MIN (SAT_MIN),
    .MARGIN  (MARGIN)
  ) u_classifier (
    .rgb565 (rgb565),
    .color  (pix_class)
  );

  // aln_vld_q keeps the post-reset zero in x/y_dly_q from faking a start of frame.
  assign sof    = aln_vld_q && (x_dly_q == 10'd0) && (y_dly_q == 10'd0);
  assign eof    = aln_vld_q && (x_dly_q == 10'd0) && (y_dly_q == EOF_ROW);
  assign sample = de_dly_q && (x_dly_q < ROI_X_END) &&
                  (y_dly_q >= ROI_Y_START) && (y_dly_q < ROI_Y_END) &&
                  !x_dly_q[0] && !y_dly_q[0];

  assign raw_winner = pick_winner(red_acc_q, green_acc_q, blue_acc_q, MIN_PIXELS);

  always_comb begin
    de_dly_d      = DE;
    x_dly_d       = x_pixel;
    y_dly_d       = y_pixel;
    aln_vld_d     = 1'b1;
    state_d       = state_q;
    red_acc_d     = red_acc_q;
    green_acc_d   = green_acc_q;
    blue_acc_d    = blue_acc_q;
    red_out_d     = red_out_q;
    green_out_d   = green_out_q;
    blue_out_d    = blue_out_q;
    color_id_d    = color_id_q;
    color_valid_d = 1'b0;
`ifdef COLOR_DETECTOR_STABLE_EN
    rep_d         = rep_q;
    last_raw_d    = last_raw_q;
`endif
    case (state_q)
      ST_WAIT_SOF: begin
        if (sof) begin
          red_acc_d   = '0;
          green_acc_d = '0;
          blue_acc_d  = '0;
          state_d     = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (sample) begin
          case (pix_class)
            RED:     if (red_acc_q != CNT_MAX) red_acc_d = red_acc_q + CNT_ONE;
            GREEN:   if (green_acc_q != CNT_MAX) green_acc_d = green_acc_q + CNT_ONE;
            BLUE:    if (blue_acc_q != CNT_MAX) blue_acc_d = blue_acc_q + CNT_ONE;
            default: ;
          endcase
        end
        if (eof) begin
          red_out_d     = red_acc_q;
          green_out_d   = green_acc_q;
          blue_out_d    = blue_acc_q;
          color_valid_d = 1'b1;
          state_d       = ST_WAIT_SOF;
`ifdef COLOR_DETECTOR_STABLE_EN
          if ((raw_winner == last_raw_q) && (rep_q != 3'd0)) begin
            rep_d = (rep_q >= STAB_CNT) ? rep_q : rep_q + 3'd1;
          end else begin
            rep_d = 3'd1;
          end
          last_raw_d = raw_winner;
          if (rep_d >= STAB_CNT) begin
            color_id_d = raw_winner;
          end
`else
          color_id_d = raw_winner;
`endif
        end
      end
      default: state_d = ST_WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_dly_q      <= 1'b0;
      x_dly_q       <= '0;
      y_dly_q       <= '0;
      aln_vld_q     <= 1'b0;
      state_q       <= ST_WAIT_SOF;
      red_acc_q     <= '0;
      green_acc_q   <= '0;
      blue_acc_q    <= '0;
      red_out_q     <= '0;
      green_out_q   <= '0;
      blue_out_q    <= '0;
      color_id_q    <= NONE;
      color_valid_q <= 1'b0;
`ifdef COLOR_DETECTOR_STABLE_EN
      rep_q         <= 3'd0;
      last_raw_q    <= NONE;
`endif
    end else begin
      de_dly_q      <= de_dly_d;
      x_dly_q       <= x_dly_d;
      y_dly_q       <= y_dly_d;
      aln_vld_q     <= aln_vld_d;
      state_q       <= state_d;
      red_acc_q     <= red_acc_d;
      green_acc_q   <= green_acc_d;
      blue_acc_q    <= blue_acc_d;
      red_out_q     <= red_out_d;
      green_out_q   <= green_out_d;
      blue_out_q    <= blue_out_d;
      color_id_q    <= color_id_d;
      color_valid_q <= color_valid_d;
`ifdef COLOR_DETECTOR_STABLE_EN
      rep_q         <= rep_d;
      last_raw_q    <= last_raw_d;
`endif
    end
  end

  assign color_id    = color_id_q;
  assign red_cnt     = red_out_q;
  assign green_cnt   = green_out_q;
  assign blue_cnt    = blue_out_q;
  assign color_valid = color_valid_q;

endmodule : color_detector
`default_nettype wire

// File: tb/tb_color_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_color_detector                                                      |
// | Scoreboard bench for color_detector using compressed synthetic frames. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_color_detector;

  localparam logic [15:0] C_RED   = 16'hF800;
  localparam logic [15:0] C_GREEN = 16'h07E0;
  localparam logic [15:0] C_BLUE  = 16'h001F;
  localparam logic [15:0] C_GRAY  = 16'h8410;
  localparam logic [15:0] C_BLACK = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        DE;
  logic [9:0]  x_pixel;
  logic [9:0]  y_pixel;
  logic [15:0] rgb565;
  logic [1:0]  color_id;
  logic [14:0] red_cnt;
  logic [14:0] green_cnt;
  logic [14:0] blue_cnt;
  logic        color_valid;

  color_detector dut (
    .clk         (clk),
    .reset       (reset),
    .DE          (DE),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .rgb565      (rgb565),
    .color_id    (color_id),
    .red_cnt     (red_cnt),
    .green_cnt   (green_cnt),
    .blue_cnt    (blue_cnt),
    .color_valid (color_valid)
  );

  always #20 clk = ~clk;

  typedef struct {
    int cyc;
    int r;
    int g;
    int b;
    int id;
  } exp_t;

  exp_t        q[$];
  int          assertions = 0;
  int          failures   = 0;
  int          cyc        = 0;
  int          pulses     = 0;
  int          m_last     = 0;
  int          m_rep      = 0;
  int          m_id       = 0;
  int          last_id    = 0;
  logic [15:0] pend       = 16'h0;

  // Pulse monitor: every pulse must match the oldest scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (color_valid) begin
      pulses++;
      assertions++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: color_valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc) begin
          failures++;
          $display("FAIL pulse_latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
        end
        assertions++;
        if (int'(red_cnt) !== e.r) begin
          failures++;
          $display("FAIL red_cnt: got %0d, required %0d", red_cnt, e.r);
        end
        assertions++;
        if (int'(green_cnt) !== e.g) begin
          failures++;
          $display("FAIL green_cnt: got %0d, required %0d", green_cnt, e.g);
        end
        assertions++;
        if (int'(blue_cnt) !== e.b) begin
          failures++;
          $display("FAIL blue_cnt: got %0d, required %0d", blue_cnt, e.b);
        end
        assertions++;
        if (int'(color_id) !== e.id) begin
          failures++;
          $display("FAIL color_id: got %0d, required %0d", color_id, e.id);
        end
      end
    end
  end

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_pix(input int x, input int y, input logic de, input logic [15:0] col);
    @(negedge clk);
    x_pixel = x[9:0];
    y_pixel = y[9:0];
    DE      = de;
    rgb565  = pend;
    pend    = col;
  endtask

  // Walks the sampled grid (even x < 320, even y in 240..478) in raster order.
  task automatic fill(input int start, input int n, input logic [15:0] col);
    for (int i = 0; i < n; i++) begin
      drive_pix(((start + i) % 160) * 2, 240 + ((start + i) / 160) * 2, 1'b1, col);
    end
  endtask

  task automatic start_frame();
    drive_pix(0, 0, 1'b0, C_BLACK);
    drive_pix(2, 0, 1'b1, C_BLACK);
  endtask

  task automatic model_push(input int r, input int g, input int b, input int raw);
    int id;
`ifdef COLOR_DETECTOR_STABLE_EN
    if (raw == m_last && m_rep != 0) m_rep = (m_rep >= 3) ? m_rep : m_rep + 1;
    else m_rep = 1;
    m_last = raw;
    if (m_rep >= 3) m_id = raw;
    id = m_id;
`else
    id = raw;
`endif
    q.push_back('{cyc + 2, r, g, b, id});
    last_id = id;
  endtask

  task automatic end_frame(input bit expect_pulse, input int r, input int g, input int b, input int raw);
    drive_pix(0, 480, 1'b0, C_BLACK);
    if (expect_pulse) model_push(r, g, b, raw);
    repeat (4) drive_pix(1, 481, 1'b0, C_BLACK);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    m_last = 0;
    m_rep  = 0;
    m_id   = 0;
    last_id = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    assertions++;
    if ({color_id, red_cnt, green_cnt, blue_cnt, color_valid} !== '0) begin
      failures++;
      $display("FAIL reset_state: id=%0d r=%0d g=%0d b=%0d v=%0d, required all 0",
               color_id, red_cnt, green_cnt, blue_cnt, color_valid);
    end
  endtask

  task automatic test_all_red();
    int p0;
    p0 = pulses;
    fill(9000, 60, C_RED);
    end_frame(1'b0, 0, 0, 0, 0);
    assertions++;
    if (pulses !== p0) begin
      failures++;
      $display("FAIL partial_frame: %0d pulses, required 0", pulses - p0);
    end
    start_frame();
    fill(0, 19200, C_RED);
    end_frame(1'b1, 19200, 0, 0, 1);
    repeat (20) drive_pix(5, 490, 1'b0, C_BLACK);
    assertions++;
    if (red_cnt !== 15'd19200 || int'(color_id) !== last_id) begin
      failures++;
      $display("FAIL hold_outputs: red=%0d id=%0d, required red=19200 id=%0d",
               red_cnt, color_id, last_id);
    end
  endtask

  task automatic test_out_of_window();
    start_frame();
    drive_pix(320, 240, 1'b1, C_BLUE);
    drive_pix(330, 250, 1'b1, C_BLUE);
    drive_pix(0, 238, 1'b1, C_BLUE);
    drive_pix(318, 238, 1'b1, C_BLUE);
    drive_pix(1, 240, 1'b1, C_BLUE);
    drive_pix(319, 478, 1'b1, C_BLUE);
    drive_pix(2, 241, 1'b1, C_BLUE);
    drive_pix(4, 244, 1'b0, C_BLUE);
    fill(0, 100, C_GRAY);
    end_frame(1'b1, 0, 0, 0, 0);
  endtask

  task automatic test_tie();
    start_frame();
    fill(0, 9600, C_RED);
    fill(9600, 9600, C_GREEN);
    end_frame(1'b1, 9600, 9600, 0, 1);
  endtask

  task automatic test_threshold();
    start_frame();
    fill(0, 200, C_BLUE);
    fill(200, 50, C_BLACK);
    end_frame(1'b1, 0, 0, 200, 0);
    start_frame();
    fill(0, 600, C_BLUE);
    end_frame(1'b1, 0, 0, 600, 3);
  endtask

  task automatic test_midframe_reset();
    int p0;
    start_frame();
    for (int y = 240; y <= 300; y += 20) drive_pix(4, y, 1'b1, C_RED);
    reset_dut();
    assertions++;
    if ({color_id, red_cnt, green_cnt, blue_cnt, color_valid} !== '0) begin
      failures++;
      $display("FAIL midframe_reset_outputs: id=%0d r=%0d g=%0d b=%0d, required all 0",
               color_id, red_cnt, green_cnt, blue_cnt);
    end
    p0 = pulses;
    fill(4900, 60, C_RED);
    end_frame(1'b0, 0, 0, 0, 0);
    assertions++;
    if (pulses !== p0) begin
      failures++;
      $display("FAIL discarded_frame: %0d pulses, required 0", pulses - p0);
    end
    start_frame();
    fill(0, 19200, C_RED);
    end_frame(1'b1, 19200, 0, 0, 1);
  endtask

  task automatic test_stable();
    int seq[8];
    seq = '{1, 1, 1, 2, 1, 2, 2, 2};
    for (int f = 0; f < 8; f++) begin
      start_frame();
      fill(0, 600, (seq[f] == 1) ? C_RED : C_GREEN);
      if (seq[f] == 1) end_frame(1'b1, 600, 0, 0, 1);
      else             end_frame(1'b1, 0, 600, 0, 2);
    end
  endtask

  initial begin
    reset   = 1'b1;
    DE      = 1'b0;
    x_pixel = 10'd1;
    y_pixel = 10'd481;
    rgb565  = 16'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_all_red();
    test_out_of_window();
    test_tie();
    test_threshold();
    test_midframe_reset();
    test_stable();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    assertions++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule : tb_color_detector
`default_nettype wire
